// File: rtl/wci_axi_arbiter_pkg.sv
// Shared definitions for the two-requester AXI-Lite arbiter.
//   state_t : FSM encoding, also exported on the debug state port
//   OKAY / SLVERR : AXI response codes
//   PROT : constant protection attributes driven on AW/AR
package wci_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [2:0] PROT   = 3'b000;

endpackage

// File: rtl/wci_axi_arbiter_if.sv
// AXI-Lite master port bundle (AW, W, B, AR, R).
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both high; the source holds valid and payload
// stable until that edge, and ready may be asserted before or after valid.
//   master : arbiter side (drives valids, addresses, write data, readies for B/R)
//   slave  : memory/peripheral side
interface wci_axi_arbiter_if;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );

endinterface

// File: rtl/wci_rr_arb2.sv
// Two-way round-robin pick.
//   req_i   : pending requests, bit N = requester N
//   last_i  : index of the requester granted most recently
//   grant_o : winning index (only meaningful when req_i != 0)
// A lone requester always wins; on contention the one that was not served
// last wins.
module wci_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o
);

    always_comb begin
        grant_o = 1'b0;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_i;
            default: grant_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/wci_axi_arbiter.sv
// Serialises single-beat read/write requests from two requesters onto one
// AXI-Lite master port, with a per-transaction watchdog.
//   oped_clk125 / oped_reset : clock, synchronous active-high reset
//   rN_req/we/addr/wdata/wstrb : requester N command (held until rN_done)
//   rN_done/rdata/resp : one-cycle completion with read data and AXI response
//   wcim0 : AXI-Lite master port (all outputs registered)
//   busy : FSM not idle; grant : requester being/last served
//   timeout_cnt : saturating count of watchdog expiries
//   dbg_state_o : current FSM state
module wci_axi_arbiter
    import wci_axi_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic        oped_clk125,
    input  logic        oped_reset,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [3:0]  r0_wstrb,
    output logic        r0_done,
    output logic [31:0] r0_rdata,
    output logic [1:0]  r0_resp,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [3:0]  r1_wstrb,
    output logic        r1_done,
    output logic [31:0] r1_rdata,
    output logic [1:0]  r1_resp,
    wci_axi_arbiter_if.master wcim0,
    output logic        busy,
    output logic        grant,
    output logic [7:0]  timeout_cnt,
    output state_t      dbg_state_o
);

    state_t      state_q, state_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic        bready_q, bready_d, rready_q, rready_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  resp_q, resp_d;
    logic        grant_q, grant_d, last_q, last_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        rr_grant;
    logic        tmo_hit;

    wci_rr_arb2 u_rr (
        .req_i   ({r1_req, r0_req}),
        .last_i  (last_q),
        .grant_o (rr_grant)
    );

    // Expire on the cycle whose increment would reach TIMEOUT; >= keeps the
    // watchdog firing even if a completing handshake skipped the exact value.
    assign tmo_hit = (TIMEOUT != 16'd0) && (tmo_q >= (TIMEOUT - 16'd1));

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        grant_d   = grant_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        tcnt_d    = tcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    grant_d = rr_grant;
                    last_d  = rr_grant;
                    addr_d  = rr_grant ? r1_addr  : r0_addr;
                    wdata_d = rr_grant ? r1_wdata : r0_wdata;
                    wstrb_d = rr_grant ? r1_wstrb : r0_wstrb;
                    tmo_d   = 16'd0;
                    if (rr_grant ? r1_we : r0_we) begin
                        state_d   = ST_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WADDR: begin
                tmo_d = tmo_q + 16'd1;
                if (wcim0.awready) awvalid_d = 1'b0;
                if (wcim0.wready)  wvalid_d  = 1'b0;
                // Each channel is finished if it already dropped or handshakes now.
                if ((!awvalid_q || wcim0.awready) && (!wvalid_q || wcim0.wready))
                    state_d = ST_WRESP;
            end
            ST_WRESP: begin
                tmo_d = tmo_q + 16'd1;
                if (wcim0.bvalid) begin
                    resp_d  = wcim0.bresp;
                    rdata_d = 32'd0;
                    state_d = ST_DONE;
                end
            end
            ST_RADDR: begin
                tmo_d = tmo_q + 16'd1;
                if (wcim0.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                tmo_d = tmo_q + 16'd1;
                if (wcim0.rvalid) begin
                    resp_d  = wcim0.rresp;
                    rdata_d = wcim0.rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A real completion this cycle beats the watchdog.
        if (tmo_hit && (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_d != ST_DONE)) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            arvalid_d = 1'b0;
            resp_d    = SLVERR;
            rdata_d   = 32'd0;
            state_d   = ST_DONE;
            tcnt_d    = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
        end

        // Readies stay up in IDLE so stragglers from a timed-out transaction drain.
        bready_d = (state_d == ST_WRESP) || (state_d == ST_IDLE);
        rready_d = (state_d == ST_RDATA) || (state_d == ST_IDLE);
    end

    always_ff @(posedge oped_clk125) begin
        if (oped_reset) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            rdata_q   <= 32'd0;
            resp_q    <= 2'd0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            tmo_q     <= 16'd0;
            tcnt_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            tmo_q     <= tmo_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign wcim0.awvalid = awvalid_q;
    assign wcim0.awaddr  = addr_q;
    assign wcim0.awprot  = PROT;
    assign wcim0.wvalid  = wvalid_q;
    assign wcim0.wdata   = wdata_q;
    assign wcim0.wstrb   = wstrb_q;
    assign wcim0.bready  = bready_q;
    assign wcim0.arvalid = arvalid_q;
    assign wcim0.araddr  = addr_q;
    assign wcim0.arprot  = PROT;
    assign wcim0.rready  = rready_q;

    assign r0_done  = (state_q == ST_DONE) && !grant_q;
    assign r1_done  = (state_q == ST_DONE) && grant_q;
    assign r0_rdata = r0_done ? rdata_q : 32'd0;
    assign r1_rdata = r1_done ? rdata_q : 32'd0;
    assign r0_resp  = r0_done ? resp_q : 2'd0;
    assign r1_resp  = r1_done ? resp_q : 2'd0;

    assign busy        = (state_q != ST_IDLE);
    assign grant       = grant_q;
    assign timeout_cnt = tcnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wci_axi_arbiter.sv
module tb_wci_axi_arbiter;
  import wci_axi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic oped_reset;
  always #5 clk = ~clk;

  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_wstrb, r1_wstrb;
  logic        r0_done, r1_done;
  logic [31:0] r0_rdata, r1_rdata;
  logic [1:0]  r0_resp, r1_resp;
  logic        busy, grant;
  logic [7:0]  timeout_cnt;
  state_t      dbg_state;

  wci_axi_arbiter_if ifc ();

  wci_axi_arbiter #(.TIMEOUT(16'd16)) dut (
    .oped_clk125 (clk),
    .oped_reset  (oped_reset),
    .r0_req      (r0_req),
    .r0_we       (r0_we),
    .r0_addr     (r0_addr),
    .r0_wdata    (r0_wdata),
    .r0_wstrb    (r0_wstrb),
    .r0_done     (r0_done),
    .r0_rdata    (r0_rdata),
    .r0_resp     (r0_resp),
    .r1_req      (r1_req),
    .r1_we       (r1_we),
    .r1_addr     (r1_addr),
    .r1_wdata    (r1_wdata),
    .r1_wstrb    (r1_wstrb),
    .r1_done     (r1_done),
    .r1_rdata    (r1_rdata),
    .r1_resp     (r1_resp),
    .wcim0       (ifc.master),
    .busy        (busy),
    .grant       (grant),
    .timeout_cnt (timeout_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus monitor (samples at the active edge) ----------------
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_done0 = 0, n_done1 = 0;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;

  always @(posedge clk) begin
    if (ifc.awvalid && ifc.awready) begin n_aw++; last_awaddr = ifc.awaddr; end
    if (ifc.wvalid && ifc.wready) begin n_w++; last_wdata = ifc.wdata; last_wstrb = ifc.wstrb; end
    if (ifc.bvalid && ifc.bready) n_b++;
    if (ifc.arvalid && ifc.arready) begin n_ar++; last_araddr = ifc.araddr; end
    if (ifc.rvalid && ifc.rready) n_r++;
    if (r0_done) n_done0++;
    if (r1_done) n_done1++;
  end

  // ---------------- slave model (drives at the falling edge) ----------------
  int cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] cfg_rdata = 32'd0;

  initial begin
    int aw_w, w_w, b_w, ar_w, r_w, b_out, r_out;
    aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0; b_out = 0; r_out = 0;
    ifc.awready = 1'b0; ifc.wready = 1'b0; ifc.arready = 1'b0;
    ifc.bvalid = 1'b0; ifc.bresp = 2'b00;
    ifc.rvalid = 1'b0; ifc.rresp = 2'b00; ifc.rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (ifc.awready) ifc.awready = 1'b0;
      else if (ifc.awvalid) begin
        if (aw_w >= cfg_aw) begin ifc.awready = 1'b1; aw_w = 0; end else aw_w++;
      end
      if (ifc.wready) ifc.wready = 1'b0;
      else if (ifc.wvalid) begin
        if (w_w >= cfg_w) begin ifc.wready = 1'b1; w_w = 0; end else w_w++;
      end
      if (ifc.arready) ifc.arready = 1'b0;
      else if (ifc.arvalid) begin
        if (ar_w >= cfg_ar) begin ifc.arready = 1'b1; ar_w = 0; end else ar_w++;
      end
      if (ifc.bvalid) begin
        if (n_b == b_out) ifc.bvalid = 1'b0;
      end else if (n_aw > b_out && n_w > b_out) begin
        if (b_w >= cfg_b) begin ifc.bvalid = 1'b1; ifc.bresp = cfg_resp; b_out++; b_w = 0; end
        else b_w++;
      end
      if (ifc.rvalid) begin
        if (n_r == r_out) ifc.rvalid = 1'b0;
      end else if (n_ar > r_out) begin
        if (r_w >= cfg_r) begin
          ifc.rvalid = 1'b1; ifc.rresp = cfg_resp; ifc.rdata = cfg_rdata; r_out++; r_w = 0;
        end else r_w++;
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  sresp;
    logic [31:0] srdata;
    logic        exp_grant;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [7:0]  exp_tcnt;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  // Drive one request pattern and wait (bounded) for a done pulse.
  task automatic wait_done(output int lat, output logic got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (r0_done || r1_done) got = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic got;
    int nb0, nd0, nr0;
    logic [31:0] ea, ed;
    vec_t v;

    //                req    we    addr          wdata          wstrb aw w b ar r  sresp  srdata         gnt   resp   rdata          lat tcnt
    vecs[0] = '{2'b01, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0000_0000, 1'b0, 2'b00, 32'h0000_0000, 3, 8'd0};
    vecs[1] = '{2'b10, 1'b1, 32'h0000_0020, 32'h55AA_33CC, 4'h3, 0, 0, 0, 0, 0, 2'b10, 32'h0000_0000, 1'b1, 2'b10, 32'h0000_0000, 3, 8'd0};
    vecs[2] = '{2'b11, 1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hA5A5_0001, 1'b0, 2'b00, 32'hA5A5_0001, 3, 8'd0};
    vecs[3] = '{2'b11, 1'b0, 32'h0000_0044, 32'h0000_0000, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h1234_5678, 1'b1, 2'b00, 32'h1234_5678, 3, 8'd0};
    vecs[4] = '{2'b11, 1'b0, 32'h0000_0048, 32'h0000_0000, 4'h0, 0, 0, 0, 0, 0, 2'b01, 32'h0BAD_BEEF, 1'b0, 2'b01, 32'h0BAD_BEEF, 3, 8'd0};
    vecs[5] = '{2'b11, 1'b0, 32'h0000_004C, 32'h0000_0000, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h8765_4321, 1'b1, 2'b00, 32'h8765_4321, 3, 8'd0};
    vecs[6] = '{2'b01, 1'b0, 32'h0000_0050, 32'h0000_0000, 4'h0, 0, 0, 0, 2, 3, 2'b00, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'hDEAD_BEEF, 8, 8'd0};
    vecs[7] = '{2'b10, 1'b1, 32'h0000_0060, 32'h0F0F_1234, 4'hC, 1, 2, 1, 0, 0, 2'b00, 32'h0000_0000, 1'b1, 2'b00, 32'h0000_0000, 6, 8'd0};
    vecs[8] = '{2'b01, 1'b0, 32'h0000_0070, 32'h0000_0000, 4'h0, 0, 0, 0, 0, 30, 2'b00, 32'hFFFF_FFFF, 1'b0, 2'b10, 32'h0000_0000, 17, 8'd1};

    r0_req = 1'b0; r0_we = 1'b0; r0_addr = 32'd0; r0_wdata = 32'd0; r0_wstrb = 4'd0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = 32'd0; r1_wdata = 32'd0; r1_wstrb = 4'd0;
    oped_reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_valids", {ifc.awvalid, ifc.wvalid, ifc.arvalid}, 3'b000);
    check("rst_readies", {ifc.bready, ifc.rready}, 2'b00);
    check("rst_busy_grant", {busy, grant}, 2'b00);
    check("rst_tcnt", timeout_cnt, 8'd0);
    check("rst_done", {r0_done, r1_done, r0_resp, r1_resp}, 6'd0);
    oped_reset = 1'b0;
    @(negedge clk);
    check("idle_readies", {ifc.bready, ifc.rready}, 2'b11);

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      cfg_aw = v.aw_d; cfg_w = v.w_d; cfg_b = v.b_d; cfg_ar = v.ar_d; cfg_r = v.r_d;
      cfg_resp = v.sresp; cfg_rdata = v.srdata;
      r0_we = v.we; r0_addr = v.addr; r0_wdata = v.wdata; r0_wstrb = v.wstrb;
      r1_we = v.we; r1_addr = v.addr ^ 32'h100; r1_wdata = ~v.wdata; r1_wstrb = ~v.wstrb;
      r0_req = v.req[0]; r1_req = v.req[1];
      wait_done(lat, got);
      check($sformatf("v%0d_got_done", i), got, 1'b1);
      if (got) begin
        ea = v.exp_grant ? (v.addr ^ 32'h100) : v.addr;
        ed = v.exp_grant ? ~v.wdata : v.wdata;
        check($sformatf("v%0d_grant", i), grant, v.exp_grant);
        check($sformatf("v%0d_done_bits", i), {r1_done, r0_done}, v.exp_grant ? 2'b10 : 2'b01);
        check($sformatf("v%0d_resp", i), v.exp_grant ? r1_resp : r0_resp, v.exp_resp);
        check($sformatf("v%0d_rdata", i), v.exp_grant ? r1_rdata : r0_rdata, v.exp_rdata);
        check($sformatf("v%0d_other_zero", i),
              v.exp_grant ? {r0_rdata, r0_resp} : {r1_rdata, r1_resp}, 34'd0);
        check($sformatf("v%0d_latency", i), lat, v.exp_lat);
        check($sformatf("v%0d_tcnt", i), timeout_cnt, v.exp_tcnt);
        if (v.we) begin
          check($sformatf("v%0d_awaddr", i), last_awaddr, ea);
          check($sformatf("v%0d_wdata", i), {last_wdata, last_wstrb},
                {ed, v.exp_grant ? ~v.wstrb : v.wstrb});
        end else begin
          check($sformatf("v%0d_araddr", i), last_araddr, ea);
        end
      end
      r0_req = 1'b0; r1_req = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Late read data after the timeout is drained in IDLE and never delivered
    nr0 = n_r; nd0 = n_done0 + n_done1;
    for (int k = 0; k < 40 && n_r == nr0; k++) @(negedge clk);
    check("late_r_accepted", n_r - nr0, 1);
    repeat (2) @(negedge clk);
    check("late_r_no_done", n_done0 + n_done1 - nd0, 0);
    check("late_r_idle", {busy, timeout_cnt}, {1'b0, 8'd1});

    // Write with wready three cycles ahead of awready
    cfg_aw = 3; cfg_w = 0; cfg_b = 0; cfg_resp = 2'b00;
    r0_we = 1'b1; r0_addr = 32'h0000_0080; r0_wdata = 32'h1111_2222; r0_wstrb = 4'hF;
    nb0 = n_b;
    r0_req = 1'b1;
    @(negedge clk);
    check("split_both_valid", {ifc.awvalid, ifc.wvalid}, 2'b11);
    @(negedge clk);
    check("split_w_first", {ifc.awvalid, ifc.wvalid}, 2'b10);
    @(negedge clk);
    check("split_aw_held", {ifc.awvalid, ifc.wvalid}, 2'b10);
    wait_done(lat, got);
    check("split_got_done", got, 1'b1);
    check("split_latency", lat + 3, 6);
    check("split_resp", {r0_done, r0_resp}, {1'b1, 2'b00});
    r0_req = 1'b0;
    repeat (3) @(negedge clk);
    check("split_one_b", n_b - nb0, 1);

    // Reset while waiting for the write response
    cfg_aw = 0; cfg_w = 0; cfg_b = 10;
    nd0 = n_done0 + n_done1;
    r0_req = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_in_wresp", dbg_state, ST_WRESP);
    oped_reset = 1'b1;
    @(negedge clk);
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_valids", {ifc.awvalid, ifc.wvalid, ifc.arvalid, ifc.bready, ifc.rready}, 5'b0);
    check("mid_rst_outs", {r0_done, r1_done, busy, grant, timeout_cnt}, 12'd0);
    oped_reset = 1'b0;
    r0_req = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", n_done0 + n_done1 - nd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
